// File: rtl/hex_snake_ctrl_pkg.sv
// Shared types and constants for the rotating seven-segment snake controller.
// Holds the run-state encoding, reset pattern, key indices and pattern helpers.
package hex_pkg;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } run_state_t;

    localparam logic [6:0] PAT_RESET = 7'b1111110;

    localparam int KEY_RUN  = 0;
    localparam int KEY_DIR  = 1;
    localparam int KEY_STEP = 2;
    localparam int KEY_LOAD = 3;
    localparam int NUM_KEYS = 4;

    // Rotate a 7-bit pattern left by n positions (0..6).
    function automatic logic [6:0] rotl7(input logic [6:0] p, input int n);
        logic [13:0] w;
        w = {p, p} << n;
        return w[13:7];
    endfunction

    // Snake of length l (0 means 1) lit from bit 0 upward; segments are active-low.
    function automatic logic [6:0] load_pattern(input logic [2:0] l);
        logic [2:0] len;
        logic [7:0] mask;
        len  = (l == 3'd0) ? 3'd1 : l;
        mask = (8'd1 << len) - 8'd1;
        return ~mask[6:0];
    endfunction

endpackage

// File: rtl/hex_snake_ctrl_if.sv
// Board-facing signal bundle: push-buttons and switches in, display and LEDs out.
// The master side drives keys/switches; the slave side is the controller.
interface hex_snake_ctrl_if;
    logic [3:0] key;
    logic [9:0] sw;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic [9:0] led;

    modport master (
        output key, sw,
        input  hex0, hex1, hex2, hex3, hex4, hex5, led
    );

    modport slave (
        input  key, sw,
        output hex0, hex1, hex2, hex3, hex4, hex5, led
    );
endinterface

// File: rtl/hex_snake_ctrl_key_edge.sv
// Push-button synchroniser with registered one-cycle pulse on each press (1->0).
// Presses are suppressed until the pipeline holds real post-reset samples.
module key_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] FILL = CW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   last_reg;
    logic [CW-1:0]          fill_reg;
    logic                   press_reg;

    // A key held low through reset never looks like a fresh press: the edge
    // detector only trusts its inputs once every stage has seen a real sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= '1;
            last_reg  <= 1'b1;
            fill_reg  <= '0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], key_n};
            last_reg  <= sync_reg[SYNC_STAGES-1];
            press_reg <= (fill_reg == FILL) && last_reg && !sync_reg[SYNC_STAGES-1];
            if (fill_reg != FILL) begin
                fill_reg <= fill_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;
endmodule

// File: rtl/hex_snake_ctrl.sv
// Snake pattern rotating across six seven-segment digits, paced by a two-level
// prescaler and controlled by run/direction/step/load push-buttons.
module hex_snake_ctrl
    import hex_pkg::*;
#(
    parameter int DIV_BASE    = 50000,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    hex_snake_ctrl_if.slave io
);
    localparam int BW = $clog2(DIV_BASE);
    localparam logic [BW-1:0] BC_LAST = BW'(DIV_BASE - 1);

    logic [NUM_KEYS-1:0] press;
    logic [6:0]          pat_reg;
    run_state_t          run_reg;
    logic                dir_reg;
    logic                tog_reg;
    logic [BW-1:0]       bc_reg;
    logic [3:0]          sc_reg;

    logic bc_wrap;
    logic timer_step;
    logic manual_step;
    logic dir_next;
    logic unused_sw;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_edge (
                .clk   (clk),
                .rst   (rst),
                .key_n (io.key[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // SC >= limit (not ==) so lowering the switches mid-count fires at the next wrap.
    assign bc_wrap     = (bc_reg == BC_LAST);
    assign timer_step  = (run_reg == RUN) && bc_wrap && (sc_reg >= io.sw[3:0]);
    assign manual_step = (run_reg == PAUSED) && press[KEY_STEP];
    assign dir_next    = dir_reg ^ press[KEY_DIR];
    assign unused_sw   = ^io.sw[9:7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg <= PAT_RESET;
            run_reg <= RUN;
            dir_reg <= 1'b0;
            tog_reg <= 1'b0;
            bc_reg  <= '0;
            sc_reg  <= '0;
        end else begin
            dir_reg <= dir_next;
            if (press[KEY_RUN]) begin
                run_reg <= (run_reg == RUN) ? PAUSED : RUN;
            end
            if (press[KEY_LOAD]) begin
                pat_reg <= load_pattern(io.sw[6:4]);
            end else if (timer_step || manual_step) begin
                pat_reg <= dir_next ? {pat_reg[0], pat_reg[6:1]} : {pat_reg[5:0], pat_reg[6]};
                tog_reg <= ~tog_reg;
            end
            // Any run-state change, load or pause restarts the period from zero.
            if (press[KEY_LOAD] || press[KEY_RUN] || (run_reg == PAUSED)) begin
                bc_reg <= '0;
                sc_reg <= '0;
            end else if (bc_wrap) begin
                bc_reg <= '0;
                sc_reg <= timer_step ? 4'd0 : sc_reg + 4'd1;
            end else begin
                bc_reg <= bc_reg + 1'b1;
            end
        end
    end

    logic [6:0] hex_arr [6];
    generate
        for (gi = 0; gi < 6; gi++) begin : g_hex
            assign hex_arr[gi] = rotl7(pat_reg, gi);
        end
    endgenerate

    assign io.hex0 = hex_arr[0];
    assign io.hex1 = hex_arr[1];
    assign io.hex2 = hex_arr[2];
    assign io.hex3 = hex_arr[3];
    assign io.hex4 = hex_arr[4];
    assign io.hex5 = hex_arr[5];
    assign io.led  = {~pat_reg, tog_reg, dir_reg, (run_reg == RUN)};
endmodule

// File: tb/tb_hex_snake_ctrl.sv
// Bench for hex_snake_ctrl: directed scenarios with literal expectations plus
// randomized keys/switches/resets checked every cycle against a behavioural model.
module tb_hex_snake_ctrl;
    localparam int DIV = 4;

    logic clk;
    logic rst;
    hex_snake_ctrl_if bus ();

    hex_snake_ctrl #(.DIV_BASE(DIV), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int         m_p;
    int         m_cnt;
    bit         m_r, m_d, m_t;
    logic [3:0] kq[$];
    logic [3:0] pr;
    bit         tstep, mstep, ld, dn;
    int         len;
    logic [51:0] exp_vec, act_vec;

    function automatic logic [6:0] rot_left(input int v, input int n);
        int r;
        r = ((v << n) | (v >> (7 - n))) & 127;
        return r[6:0];
    endfunction

    task automatic model_reset();
        m_p = 7'b1111110; m_r = 1; m_d = 0; m_t = 0; m_cnt = 0;
        kq.delete();
        cyc = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                cyc++;
                pr = 4'b0000;
                if (kq.size() >= 4) begin
                    for (int i = 0; i < 4; i++)
                        pr[i] = kq[kq.size()-4][i] & ~kq[kq.size()-3][i];
                end
                kq.push_back(bus.key);
                if (kq.size() > 8) void'(kq.pop_front());
                ld = pr[3];
                dn = m_d ^ pr[1];
                tstep = 0;
                if (m_r) begin
                    m_cnt++;
                    if ((m_cnt % DIV == 0) && (m_cnt / DIV - 1 >= int'(bus.sw[3:0]))) tstep = 1;
                end
                mstep = !m_r && pr[2];
                if (ld) begin
                    len = (bus.sw[6:4] == 0) ? 1 : int'(bus.sw[6:4]);
                    m_p = (~((1 << len) - 1)) & 127;
                end else if (tstep || mstep) begin
                    m_p = dn ? rot_left(m_p, 6) : rot_left(m_p, 1);
                    m_t = !m_t;
                end
                m_d = dn;
                if (ld || !m_r || pr[0] || tstep) m_cnt = 0;
                if (pr[0]) m_r = !m_r;
            end
            #1;
            exp_vec = {rot_left(m_p, 0), rot_left(m_p, 1), rot_left(m_p, 2), rot_left(m_p, 3),
                       rot_left(m_p, 4), rot_left(m_p, 5), 7'(~m_p), m_t, m_d, m_r};
            act_vec = {bus.hex0, bus.hex1, bus.hex2, bus.hex3, bus.hex4, bus.hex5, bus.led};
            tests++;
            if (act_vec !== exp_vec) begin
                fails++;
                $display("FAIL model cyc=%0d got=%h expected=%h", cyc, act_vec, exp_vec);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the key low for three sampling edges; returns just before its effect edge.
    task automatic press_key(input int k);
        @(negedge clk);
        bus.key[k] = 1'b0;
        $display("[TB] press key%0d at cycle %0d", k, cyc);
        repeat (3) @(negedge clk);
        bus.key[k] = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hex0"}, 32'(bus.hex0), 32'b1111110);
        chk({tag, "_hex1"}, 32'(bus.hex1), 32'b1111101);
        chk({tag, "_hex2"}, 32'(bus.hex2), 32'b1111011);
        chk({tag, "_hex3"}, 32'(bus.hex3), 32'b1110111);
        chk({tag, "_hex4"}, 32'(bus.hex4), 32'b1101111);
        chk({tag, "_hex5"}, 32'(bus.hex5), 32'b1011111);
        chk({tag, "_led"},  32'(bus.led),  32'b0000001001);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.key = 4'hF;
        bus.sw  = 10'd0;
        tick(2);
        chk_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;

        tick(4);                                  // edge 4: first step
        chk("step1_hex0", 32'(bus.hex0), 32'b1111101);
        chk("step1_led2", 32'(bus.led[2]), 32'd1);
        tick(24);                                 // edge 28: seven steps
        chk("step7_hex0", 32'(bus.hex0), 32'b1111110);

        bus.sw[6:4] = 3'd3;
        press_key(3);                             // effect at edge 32, a timer step edge
        chk("load_pending", 32'(bus.hex0), 32'b1111110);
        tick(1);
        chk("load_hex0", 32'(bus.hex0), 32'b1111000);
        chk("load_keeps_t", 32'(bus.led[2]), 32'd1);
        tick(3);
        chk("load_hold", 32'(bus.hex0), 32'b1111000);
        tick(1);
        chk("load_next_step", 32'(bus.hex0), 32'b1110001);

        press_key(1);                             // effect at edge 40 with a step
        tick(1);
        chk("dir_led1", 32'(bus.led[1]), 32'd1);
        chk("dir_same_cycle", 32'(bus.hex0), 32'b1111000);
        bus.sw[6:4] = 3'd1;
        press_key(3);
        tick(1);                                  // edge 44
        chk("reload_hex0", 32'(bus.hex0), 32'b1111110);
        tick(4);                                  // edge 48
        chk("rot_right", 32'(bus.hex0), 32'b0111111);

        press_key(0);                             // effect at edge 52 with a step
        chk("pause_pending", 32'(bus.led[0]), 32'd1);
        tick(1);
        chk("pause_led0", 32'(bus.led[0]), 32'd0);
        chk("pause_step_applied", 32'(bus.hex0), 32'b1011111);
        tick(40);
        chk("pause_frozen", 32'(bus.hex0), 32'b1011111);
        press_key(2);
        tick(1);
        chk("manual_step", 32'(bus.hex0), 32'b1101111);
        tick(10);
        chk("manual_once", 32'(bus.hex0), 32'b1101111);
        press_key(0);
        tick(1);                                  // edge 110
        chk("resume_led0", 32'(bus.led[0]), 32'd1);
        tick(3);
        chk("resume_wait", 32'(bus.hex0), 32'b1101111);
        tick(1);
        chk("resume_step", 32'(bus.hex0), 32'b1110111);

        bus.sw[3:0] = 4'd3;
        tick(15);
        chk("div16_wait", 32'(bus.hex0), 32'b1110111);
        tick(1);                                  // edge 130
        chk("div16_step", 32'(bus.hex0), 32'b1111011);
        tick(16);                                 // edge 146
        chk("div16_step2", 32'(bus.hex0), 32'b1111101);
        tick(9);                                  // edge 155: SC = 2
        bus.sw[3:0] = 4'd0;
        tick(2);
        chk("lower_wait", 32'(bus.hex0), 32'b1111101);
        tick(1);
        chk("lower_step", 32'(bus.hex0), 32'b1111110);
        tick(4);
        chk("lower_after", 32'(bus.hex0), 32'b0111111);

        // Key held low across a reset pulse.
        @(negedge clk); bus.key[0] = 1'b0;
        tick(2);
        @(negedge clk); rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        tick(2);
        @(negedge clk); rst = 1'b0;
        tick(12);
        chk("held_no_press", 32'(bus.led[0]), 32'd1);
        @(negedge clk); bus.key[0] = 1'b1;
        tick(6);
        chk("release_no_press", 32'(bus.led[0]), 32'd1);
        press_key(0);
        tick(1);
        chk("repress_pause", 32'(bus.led[0]), 32'd0);
        press_key(0);
        tick(1);
        chk("repress_run", 32'(bus.led[0]), 32'd1);

        // Randomized phase, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) rst = 1'b1;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) bus.key[i] = ~bus.key[i];
            if ($urandom_range(0, 39) == 0) begin
                bus.sw[3:0] = 4'($urandom_range(0, 3));
                bus.sw[9:4] = 6'($urandom_range(0, 63));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.key = 4'hF;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
